// File: rtl/knight_tour_solver.sv
// rtl/knight_tour_solver.sv - depth-first backtracking knight's-tour engine with indexed move readout
// Searches W x H boards from a start square; moves are stored one-hot for random-access reads.
module knight_tour_solver #(
  parameter int BOARD_W = 5,
  parameter int BOARD_H = 5,
  parameter int MOVES   = BOARD_W * BOARD_H - 1,
  parameter int IW      = $clog2(BOARD_W * BOARD_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic          abort,
  input  logic [2:0]    x_start,
  input  logic [2:0]    y_start,
  input  logic [IW-1:0] indx,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic          solved,
  output logic [7:0]    move,
  output logic [15:0]   backups
);

  localparam int SQ    = BOARD_W * BOARD_H;
  localparam int DEPTH = 1 << IW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_POSSIBLE,
    S_TRY,
    S_BACKUP
  } state_t;

  state_t                 state_q, state_d;
  logic [SQ-1:0]          board_q, board_d;
  logic [DEPTH-1:0][7:0]  last_move_q, last_move_d;
  logic [DEPTH-1:0][7:0]  poss_q, poss_d;
  logic [2:0]             xx_q, xx_d;
  logic [2:0]             yy_q, yy_d;
  logic [IW-1:0]          move_num_q, move_num_d;
  logic [7:0]             move_try_q, move_try_d;
  logic [15:0]            backups_q, backups_d;
  logic                   done_q, done_d;
  logic                   fail_q, fail_d;
  logic                   solved_q, solved_d;

  // Offsets are returned as 3-bit two's complement; position updates wrap
  // harmlessly because only in-board targets are ever taken.
  function automatic logic [2:0] off_dx(input logic [7:0] m);
    logic [2:0] d;
    case (m)
      8'h01, 8'h10: d = 3'b111;
      8'h02, 8'h20: d = 3'b001;
      8'h04, 8'h08: d = 3'b110;
      8'h40, 8'h80: d = 3'b010;
      default:      d = 3'b000;
    endcase
    return d;
  endfunction

  function automatic logic [2:0] off_dy(input logic [7:0] m);
    logic [2:0] d;
    case (m)
      8'h01, 8'h02: d = 3'b010;
      8'h04, 8'h80: d = 3'b001;
      8'h08, 8'h40: d = 3'b111;
      8'h10, 8'h20: d = 3'b110;
      default:      d = 3'b000;
    endcase
    return d;
  endfunction

  function automatic logic [IW-1:0] sq_idx(input logic [2:0] x, input logic [2:0] y);
    return IW'(y) * IW'(BOARD_W) + IW'(x);
  endfunction

  logic [7:0] legal;

  for (genvar k = 0; k < 8; k++) begin : g_cand
    logic [2:0]        dx3, dy3;
    logic signed [4:0] tx, ty;
    logic              in_board;
    assign dx3 = off_dx(8'(1 << k));
    assign dy3 = off_dy(8'(1 << k));
    assign tx  = $signed({2'b00, xx_q}) + $signed({{2{dx3[2]}}, dx3});
    assign ty  = $signed({2'b00, yy_q}) + $signed({{2{dy3[2]}}, dy3});
    assign in_board = !tx[4] && !ty[4] &&
                      (tx[3:0] < 4'(BOARD_W)) && (ty[3:0] < 4'(BOARD_H));
    assign legal[k] = in_board && !board_q[sq_idx(tx[2:0], ty[2:0])];
  end

  logic          start_bad;
  logic          try_hit;
  logic [2:0]    fwd_x, fwd_y;
  logic [IW-1:0] prev_num;
  logic [7:0]    back_move;
  logic [2:0]    back_x, back_y;

  assign start_bad = ({1'b0, x_start} >= 4'(BOARD_W)) || ({1'b0, y_start} >= 4'(BOARD_H));
  assign try_hit   = |(poss_q[move_num_q] & move_try_q);
  assign fwd_x     = xx_q + off_dx(move_try_q);
  assign fwd_y     = yy_q + off_dy(move_try_q);
  assign prev_num  = move_num_q - IW'(1);
  assign back_move = last_move_q[prev_num];
  assign back_x    = xx_q - off_dx(back_move);
  assign back_y    = yy_q - off_dy(back_move);

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    last_move_d = last_move_q;
    poss_d      = poss_q;
    xx_d        = xx_q;
    yy_d        = yy_q;
    move_num_d  = move_num_q;
    move_try_d  = move_try_q;
    backups_d   = backups_q;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    solved_d    = solved_q;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (start_bad) begin
            fail_d = 1'b1;
          end else begin
            board_d    = '0;
            move_num_d = '0;
            backups_d  = '0;
            solved_d   = 1'b0;
            xx_d       = x_start;
            yy_d       = y_start;
            state_d    = S_INIT;
          end
        end
      end
      S_INIT: begin
        board_d[sq_idx(xx_q, yy_q)] = 1'b1;
        state_d = S_POSSIBLE;
      end
      S_POSSIBLE: begin
        poss_d[move_num_q] = legal;
        move_try_d = 8'h01;
        state_d    = S_TRY;
      end
      S_TRY: begin
        if (try_hit) begin
          xx_d = fwd_x;
          yy_d = fwd_y;
          board_d[sq_idx(fwd_x, fwd_y)] = 1'b1;
          last_move_d[move_num_q] = move_try_q;
          move_num_d = move_num_q + IW'(1);
          if (move_num_q == IW'(MOVES - 1)) begin
            done_d   = 1'b1;
            solved_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_POSSIBLE;
          end
        end else if (move_try_q != 8'h80) begin
          move_try_d = move_try_q << 1;
        end else if (move_num_q == '0) begin
          fail_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_BACKUP;
        end
      end
      S_BACKUP: begin
        board_d[sq_idx(xx_q, yy_q)] = 1'b0;
        xx_d       = back_x;
        yy_d       = back_y;
        move_num_d = prev_num;
        move_try_d = back_move << 1;
        if (backups_q != 16'hFFFF) begin
          backups_d = backups_q + 16'd1;
        end
        // A retracted last-candidate move leaves nothing to try here; keep unwinding.
        if (back_move == 8'h80) begin
          if (prev_num == '0) begin
            fail_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_TRY;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      solved_d = 1'b0;
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        fail_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      board_q     <= '0;
      last_move_q <= '0;
      poss_q      <= '0;
      xx_q        <= '0;
      yy_q        <= '0;
      move_num_q  <= '0;
      move_try_q  <= '0;
      backups_q   <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      solved_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      last_move_q <= last_move_d;
      poss_q      <= poss_d;
      xx_q        <= xx_d;
      yy_q        <= yy_d;
      move_num_q  <= move_num_d;
      move_try_q  <= move_try_d;
      backups_q   <= backups_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      solved_q    <= solved_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign fail    = fail_q;
  assign solved  = solved_q;
  assign backups = backups_q;
  assign move    = (indx < IW'(MOVES)) ? last_move_q[indx] : 8'h00;

endmodule

// File: doc/knight_tour_solver.md
# knight_tour_solver

Parametrised knight's-tour engine for rectangular boards from 3x3 to 8x8. On `go` it runs a depth-first backtracking search from a given start square and stores the resulting move list for random-access readout. It sits between the command/UART layer, which supplies the start square and reads moves by index, and the knight movement sequencer. Over the fixed 5x5 solver it adds:

- configurable board width and height;
- explicit failure reporting;
- abort and busy status;
- a backtrack statistics counter.

## Interface
- `BOARD_W`, default 5: board columns, legal 3..8.
- `BOARD_H`, default 5: board rows, legal 3..8.
- `MOVES`, derived, `BOARD_W*BOARD_H-1`: moves in a full tour.
- `IW`, derived, `$clog2(BOARD_W*BOARD_H)`: index and move-counter width.
- `clk` input, 1: system clock. Reset `rst_n`, asynchronous, active-low; clock `clk`.
- `rst_n` input, 1: asynchronous active-low reset.
- `go` input, 1: start a search. Sampled only in IDLE.
- `abort` input, 1: terminate the search and return to IDLE.
- `x_start` input, 3: start column.
- `y_start` input, 3: start row.
- `indx` input, IW: index of the stored move to read.
- `busy` output, 1: high in every state except IDLE.
- `done` output, 1: one-cycle pulse when a tour is complete.
- `fail` output, 1: one-cycle pulse when no tour exists or the start square is invalid.
- `solved` output, 1: set with `done`; cleared by `go`, `abort` or reset.
- `move` output, 8: one-hot move stored at `indx`.
- `backups` output, 16: count of BACKUP cycles in the current or last search; saturates at 0xFFFF.

## Operation
- Move encoding (bit: dx,dy):
  - b0: -1,+2
  - b1: +1,+2
  - b2: -2,+1
  - b3: -2,-1
  - b4: -1,-2
  - b5: +1,-2
  - b6: +2,-1
  - b7: +2,+1
- Candidates are always tried LSB first.
- Storage:
  - board: W×H visited bits.
  - `last_move[0..MOVES-1]`: 8 bits each.
  - `poss[0..MOVES-1]`: 8 bits each.
  - `xx`, `yy`: 3 bits each.
  - `move_num`: IW bits.
  - `move_try`: 8 bits, one-hot.
- Bounds arithmetic: target = position + offset, computed signed at 5 bits. A target is legal only if 0 ≤ target < `BOARD_W` (x) or < `BOARD_H` (y) and the target square is unvisited. No 3-bit wrap is permitted.
- State machine:
  - **IDLE**:
    - `go` with `x_start` ≥ `BOARD_W` or `y_start` ≥ `BOARD_H`: pulse `fail` next cycle; stay in IDLE.
    - `go` with a valid start: clear board, `move_num`, `backups` and `solved`; go to INIT.
  - **INIT**: mark the start square visited; `xx`,`yy` ← start; go to POSSIBLE.
  - **POSSIBLE**: `poss[move_num]` ← legal mask from (`xx`,`yy`); `move_try` ← 0x01; go to TRY.
  - **TRY**:
    - `poss[move_num] & move_try` nonzero: move and mark the target, `last_move[move_num]` ← `move_try`, `move_num`++. If `move_num` was `MOVES-1`, pulse `done`, set `solved` and go to IDLE. Otherwise go to POSSIBLE.
    - Else if `move_try` ≠ 0x80: shift `move_try` left one bit; stay in TRY.
    - Else, if `move_num` = 0: pulse `fail`, go to IDLE. Otherwise go to BACKUP.
  - **BACKUP**:
    - Unmark (`xx`,`yy`); subtract the offset of `last_move[move_num-1]`; `move_num`--; `move_try` ← `last_move[move_num-1]` << 1; `backups`++ (saturating).
    - If that last move was 0x80: if the new `move_num` = 0, pulse `fail` and go to IDLE; else stay in BACKUP.
    - Otherwise go to TRY.
- `abort` in any non-IDLE state returns to IDLE next cycle. It produces no `done`/`fail` pulse, clears `solved`, and leaves board contents don't-care. `abort` has priority over every transition in the same cycle.
- `go` while `busy` is ignored.
- `move` = `last_move[indx]`, combinational. It is 0x00 when `indx` ≥ `MOVES`. It is valid only while `solved`=1.

## Timing
- Reset values:
  - state IDLE
  - `busy`, `done`, `fail`, `solved` = 0
  - `backups` = 0
  - all `last_move` = 0, so `move` = 0
  - `xx`, `yy`, `move_num`, `move_try` = 0
- `busy` rises the cycle after an accepted `go`. It falls in the same cycle that `done`/`fail` is high.
- Minimum latency for a `go` → `done` run with no backtracking:
  - 1 cycle in INIT.
  - 1 cycle in POSSIBLE per move.
  - 1–8 cycles in TRY per move.
- Invalid start: `fail` high exactly 1 cycle after `go`; `busy` stays 0.
- `done` and `fail` are never high together and never high for more than 1 cycle.
- `solved` rises with `done` and holds until the next accepted `go`, an `abort`, or reset.
- `move` responds to `indx` in the same cycle (combinational path).

## Test plan
- 5x5, start (2,2), `go`:
  - `done` pulses once; `solved`=1.
  - Replaying `move` for `indx` 0..23 from (2,2) visits 24 distinct in-board squares, all ≠ (2,2).
  - `move` at `indx`=24 reads 0x00.
- 5x5, start (0,1) (odd colour):
  - `fail` pulses once, `done` never pulses, `solved`=0.
  - `backups` > 0; `busy` returns to 0.
- `BOARD_W`=`BOARD_H`=3, start (0,0): `fail` after exhausting the search; `busy` drops in the same cycle.
- 5x5, `x_start`=5: `fail` exactly 1 cycle after `go`, `busy` never asserts.
- 6x5, start (0,0): `done` pulses; replaying 29 moves covers all 30 squares exactly once, checked against bounds 6×5.
- 5x5 from (2,2):
  - Assert `abort` 100 cycles after `go`: IDLE next cycle, no `done`/`fail`, `solved`=0.
  - A second `go` pulsed while `busy`=1 is ignored.
  - A fresh `go` afterwards completes identically to the first scenario.
